filter_load_ctrl: RTL and testbench

FILTER_LOAD_CTRL -- requirements
Module: filter_load_ctrl

---
 rtl/filter_load_ctrl.sv | 113 +++++++++++
 tb/tb_filter_load_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/filter_load_ctrl.sv
// Weight-load sequencer: streams weight words into the PE array, tagging each
// word with its (filter, kernel) index for pe_decoder.
module filter_load_ctrl #(
  parameter int MAX_FILTERNUM   = 64,
  parameter int MAX_KERNELNUM   = 8,
  parameter int FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
  parameter int KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  input  logic                       w_valid,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic                       w_ready,
  output logic [FILTERNUM_WIDTH-1:0] filter_cnt,
  output logic [KERNELNUM_WIDTH-1:0] kernel_cnt,
  output logic                       filter_load,
  output logic [DATA_WIDTH-1:0]      pe_wdata,
  output logic                       pe_wen,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [FILTERNUM_WIDTH-1:0] MAX_F = FILTERNUM_WIDTH'(MAX_FILTERNUM);
  localparam logic [KERNELNUM_WIDTH-1:0] MAX_K = KERNELNUM_WIDTH'(MAX_KERNELNUM);
  localparam logic [FILTERNUM_WIDTH-1:0] ONE_F = FILTERNUM_WIDTH'(1);
  localparam logic [KERNELNUM_WIDTH-1:0] ONE_K = KERNELNUM_WIDTH'(1);

  logic [1:0]                 state_reg, state_next;
  logic [FILTERNUM_WIDTH-1:0] nf_reg, f_reg, filter_cnt_reg;
  logic [KERNELNUM_WIDTH-1:0] nk_reg, k_reg, kernel_cnt_reg;
  logic [DATA_WIDTH-1:0]      pe_wdata_reg;
  logic                       pe_wen_reg, filter_load_reg, cfg_err_reg;
  logic                       cfg_valid, accept, last_k, last_word, start_ok;

  assign cfg_valid = (num_filter >= ONE_F) && (num_filter <= MAX_F) &&
                     (num_kernel >= ONE_K) && (num_kernel <= MAX_K);
  assign start_ok  = (state_reg == IDLE) && start && cfg_valid;
  assign w_ready   = (state_reg == LOAD);
  assign accept    = w_valid && w_ready;
  assign last_k    = (k_reg == nk_reg - ONE_K);
  assign last_word = last_k && (f_reg == nf_reg - ONE_F);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = LOAD;
      // abort wins over the final-word transition
      LOAD:    if (abort) state_next = IDLE;
               else if (accept && last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      nf_reg          <= '0;
      nk_reg          <= '0;
      f_reg           <= '0;
      k_reg           <= '0;
      filter_cnt_reg  <= '0;
      kernel_cnt_reg  <= '0;
      pe_wdata_reg    <= '0;
      pe_wen_reg      <= 1'b0;
      filter_load_reg <= 1'b1;
      cfg_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      filter_load_reg <= (state_next == IDLE);
      pe_wen_reg      <= accept;
      cfg_err_reg     <= (state_reg == IDLE) && start && !cfg_valid;
      if (start_ok) begin
        nf_reg <= num_filter;
        nk_reg <= num_kernel;
        f_reg  <= '0;
        k_reg  <= '0;
      end else if (accept) begin
        if (last_k) begin
          k_reg <= '0;
          f_reg <= f_reg + ONE_F;
        end else begin
          k_reg <= k_reg + ONE_K;
        end
      end
      if (accept) begin
        pe_wdata_reg   <= w_data;
        filter_cnt_reg <= f_reg;
        kernel_cnt_reg <= k_reg;
      end
    end
  end

  assign filter_cnt  = filter_cnt_reg;
  assign kernel_cnt  = kernel_cnt_reg;
  assign pe_wdata    = pe_wdata_reg;
  assign pe_wen      = pe_wen_reg;
  assign filter_load = filter_load_reg;
  assign cfg_err     = cfg_err_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Bench for filter_load_ctrl: a queue of expected (filter, kernel) words is
// built at each accepted start and drained as words are accepted.
module tb_filter_load_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, w_valid;
  logic [6:0]  num_filter;
  logic [3:0]  num_kernel;
  logic [15:0] w_data;
  logic        w_ready, filter_load, pe_wen, busy, done, cfg_err;
  logic [6:0]  filter_cnt;
  logic [3:0]  kernel_cnt;
  logic [15:0] pe_wdata;

  filter_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_filter(num_filter), .num_kernel(num_kernel),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .filter_cnt(filter_cnt), .kernel_cnt(kernel_cnt), .filter_load(filter_load),
    .pe_wdata(pe_wdata), .pe_wen(pe_wen), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { int f; int k; } fk_t;
  fk_t pending[$];

  int checks = 0;
  int errors = 0;
  bit m_loading, m_in_done;
  int exp_f, exp_k, exp_data;
  bit exp_wen, exp_cfg;
  int wen_seen, done_seen, cfg_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_busy;
    exp_busy = m_loading || m_in_done;
    check({tag, ".w_ready"},     32'(w_ready),     32'(m_loading));
    check({tag, ".busy"},        32'(busy),        32'(exp_busy));
    check({tag, ".done"},        32'(done),        32'(m_in_done));
    check({tag, ".cfg_err"},     32'(cfg_err),     32'(exp_cfg));
    check({tag, ".filter_load"}, 32'(filter_load), 32'(!exp_busy));
    check({tag, ".pe_wen"},      32'(pe_wen),      32'(exp_wen));
    check({tag, ".filter_cnt"},  32'(filter_cnt),  32'(exp_f));
    check({tag, ".kernel_cnt"},  32'(kernel_cnt),  32'(exp_k));
    check({tag, ".pe_wdata"},    32'(pe_wdata),    32'(exp_data));
  endtask

  // One clock: predict from the inputs present at the edge, then compare.
  task automatic cycle(input string tag);
    bit acc, st, ab;
    int nf, nk, d;
    acc = m_loading && w_valid;
    st = start; ab = abort; nf = int'(num_filter); nk = int'(num_kernel); d = int'(w_data);
    @(posedge clk); #1;
    exp_cfg = 0;
    exp_wen = acc;
    if (acc) begin
      exp_f = pending[0].f; exp_k = pending[0].k; exp_data = d;
      void'(pending.pop_front());
      wen_seen++;
    end
    if (m_loading) begin
      if (ab) begin m_loading = 0; pending.delete(); end
      else if (acc && pending.size() == 0) begin m_loading = 0; m_in_done = 1; end
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (st) begin
      if (nf >= 1 && nf <= 64 && nk >= 1 && nk <= 8) begin
        m_loading = 1;
        for (int f = 0; f < nf; f++)
          for (int k = 0; k < nk; k++) pending.push_back('{f: f, k: k});
      end else begin
        exp_cfg = 1;
        cfg_seen++;
      end
    end
    if (m_in_done) done_seen++;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_loading = 0; m_in_done = 0; pending.delete();
    exp_f = 0; exp_k = 0; exp_data = 0; exp_wen = 0; exp_cfg = 0;
  endtask

  // Launch a load and run it to completion with w_valid asserted pct% of cycles.
  task automatic run_load(input string tag, input int nf, input int nk, input int pct,
                          output int cycles);
    start = 1; num_filter = 7'(nf); num_kernel = 4'(nk);
    cycle({tag, ".start"});
    start = 0;
    cycles = 0;
    for (int i = 0; i < 4000 && (m_loading || m_in_done); i++) begin
      w_valid = ($urandom_range(99) < pct);
      w_data = 16'($urandom);
      cycle(tag);
      cycles++;
    end
    w_valid = 0;
    check({tag, ".timeout"}, 32'(m_loading || m_in_done), 32'd0);
  endtask

  initial begin
    int c, w0, d0;
    bit pat[5];
    reset = 0; start = 0; abort = 0; w_valid = 0; w_data = 0;
    num_filter = 0; num_kernel = 0;
    wen_seen = 0; done_seen = 0; cfg_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 reset = 1;

    // 2x2, continuous valid: 4 words, then one DONE cycle
    w0 = wen_seen; d0 = done_seen;
    run_load("l2x2", 2, 2, 100, c);
    check("l2x2.words", 32'(wen_seen - w0), 32'd4);
    check("l2x2.done_cnt", 32'(done_seen - d0), 32'd1);
    check("l2x2.cycles", 32'(c), 32'd5);

    // 1x3 with gapped valid
    w0 = wen_seen;
    pat = '{1, 0, 1, 0, 1};
    start = 1; num_filter = 1; num_kernel = 3;
    cycle("gap.start");
    start = 0;
    for (int i = 0; i < 5; i++) begin
      w_valid = pat[i]; w_data = 16'($urandom);
      cycle("gap");
    end
    w_valid = 0;
    cycle("gap.end");
    check("gap.words", 32'(wen_seen - w0), 32'd3);

    // rejected configurations
    w0 = cfg_seen;
    num_filter = 0;  num_kernel = 2; start = 1; cycle("cfg.nf0");
    num_filter = 65; num_kernel = 2; cycle("cfg.nf65");
    num_filter = 3;  num_kernel = 9; cycle("cfg.nk9");
    start = 0;
    cycle("cfg.idle");
    check("cfg.pulses", 32'(cfg_seen - w0), 32'd3);

    // full-size load
    w0 = wen_seen; d0 = done_seen;
    run_load("full", 64, 8, 70, c);
    check("full.words", 32'(wen_seen - w0), 32'd512);
    check("full.done_cnt", 32'(done_seen - d0), 32'd1);
    check("full.last_f", 32'(filter_cnt), 32'd63);
    check("full.last_k", 32'(kernel_cnt), 32'd7);

    // random loads, abort in IDLE ignored
    for (int r = 0; r < 6; r++) begin
      abort = 1; cycle("abort_idle"); abort = 0;
      run_load("rand", $urandom_range(1, 6), $urandom_range(1, 8), 60, c);
    end

    // asynchronous reset after the third accepted word
    start = 1; num_filter = 2; num_kernel = 4;
    cycle("ar.start");
    start = 0; w_valid = 1;
    for (int i = 0; i < 3; i++) begin w_data = 16'($urandom); cycle("ar"); end
    w_valid = 0;
    reset = 0;
    #1;
    model_reset();
    check_all("ar.async");
    #2 reset = 1;
    run_load("ar.reload", 2, 4, 100, c);

    // abort with start held high
    d0 = done_seen;
    start = 1; num_filter = 4; num_kernel = 4;
    cycle("ab.start");
    w_valid = 1;
    for (int i = 0; i < 3; i++) begin w_data = 16'($urandom); cycle("ab.hold"); end
    abort = 1; w_data = 16'($urandom);
    cycle("ab.abort");
    abort = 0; start = 0; w_valid = 0;
    cycle("ab.after");
    check("ab.no_done", 32'(done_seen - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
